// File: rtl/hnf_snreq_queue.sv
// hnf_snreq_queue: buffers ReadNoSnp flits from the SLC/SF miss path and issues
// them in order on the CHI TXREQ link, gated by link-layer credits.

package hnf_snreq_pkg;
  // Request flit fields carried unmodified from the SLC to the SN-F
  typedef struct packed {
    logic [47:0] addr;
    logic [2:0]  size;
    logic [11:0] txn_id;
    logic [10:0] src_id;
    logic [10:0] return_nid;
    logic [11:0] return_txn_id;
  } reqflit_t;
endpackage

module hnf_snreq_queue
  import hnf_snreq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAX_CRD = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  reqflit_t               read_no_snp,
  input  logic                   read_no_snp_v,
  output logic                   txreq_flitpend,
  output logic                   txreq_flitv,
  output reqflit_t               txreq_flit,
  input  logic                   txreq_lcrdv,
  output logic                   full,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow,
  output logic                   crd_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CRD_W = $clog2(MAX_CRD + 1);

  // Flit storage; no reset so it can map onto block RAM
  reqflit_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [CRD_W-1:0] crd_reg;
  logic [CRD_W-1:0] crd_next;
  logic             pend_reg;
  logic             flitv_reg;
  reqflit_t         flit_reg;
  logic             overflow_reg;
  logic             crd_err_reg;

  logic full_c;
  logic push;
  logic send;
  logic crd_sat;

  // Push/send decisions, next count and next credit value
  always_comb begin
    full_c     = (count_reg == CNT_W'(DEPTH));
    push       = read_no_snp_v & ~full_c;
    // pend_reg guarantees flitpend was visible for a cycle before flitv
    send       = (count_reg != '0) & (crd_reg != '0) & pend_reg;
    count_next = count_reg + CNT_W'(push) - CNT_W'(send);
    // A credit beyond the maximum with nothing consumed is a protocol error
    crd_sat    = (crd_reg == CRD_W'(MAX_CRD)) & txreq_lcrdv & ~send;
    crd_next   = crd_reg;
    if (txreq_lcrdv & ~send & ~crd_sat) begin
      crd_next = crd_reg + CRD_W'(1);
    end else if (send & ~txreq_lcrdv) begin
      crd_next = crd_reg - CRD_W'(1);
    end
  end

  // Storage write; an empty-FIFO push still goes through the array (no bypass)
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= read_no_snp;
    end
  end

  // Pointers, count, credits, pending flag and sticky error flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      crd_reg      <= '0;
      pend_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      crd_err_reg  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (send) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
      crd_reg   <= crd_next;
      pend_reg  <= (count_next != '0);
      if (read_no_snp_v & full_c) begin
        overflow_reg <= 1'b1;
      end
      if (crd_sat) begin
        crd_err_reg <= 1'b1;
      end
    end
  end

  // Registered read into the TXREQ flit; the flit holds while nothing is sent
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flitv_reg <= 1'b0;
      flit_reg  <= '0;
    end else begin
      flitv_reg <= send;
      if (send) begin
        flit_reg <= mem[rd_ptr_reg];
      end
    end
  end

  assign txreq_flitpend = pend_reg;
  assign txreq_flitv    = flitv_reg;
  assign txreq_flit     = flit_reg;
  assign full           = full_c;
  assign occupancy      = count_reg;
  assign overflow       = overflow_reg;
  assign crd_err        = crd_err_reg;

endmodule

// File: tb/tb_hnf_snreq_queue.sv
// tb_hnf_snreq_queue: scoreboard bench for hnf_snreq_queue with directed
// scenarios plus a randomized phase against a queue/credit reference model.

module tb_hnf_snreq_queue;
  import hnf_snreq_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MAX_CRD = 15;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  reqflit_t               read_no_snp = '0;
  logic                   read_no_snp_v = 1'b0;
  logic                   txreq_flitpend;
  logic                   txreq_flitv;
  reqflit_t               txreq_flit;
  logic                   txreq_lcrdv = 1'b0;
  logic                   full;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   overflow;
  logic                   crd_err;

  hnf_snreq_queue #(.DEPTH(DEPTH), .MAX_CRD(MAX_CRD)) dut (
    .clock          (clock),
    .reset          (reset),
    .read_no_snp    (read_no_snp),
    .read_no_snp_v  (read_no_snp_v),
    .txreq_flitpend (txreq_flitpend),
    .txreq_flitv    (txreq_flitv),
    .txreq_flit     (txreq_flit),
    .txreq_lcrdv    (txreq_lcrdv),
    .full           (full),
    .occupancy      (occupancy),
    .overflow       (overflow),
    .crd_err        (crd_err)
  );

  always #5 clock = ~clock;

  int tests    = 0;
  int fails    = 0;
  int sent_cnt = 0;

  // Scoreboard: flits accepted by the model, in expected output order
  reqflit_t exp_q[$];
  reqflit_t mon_exp;

  // Reference model state (abstract counts, not the RTL's registers)
  int m_cnt;
  int m_crd;
  bit m_pend;
  bit m_flitv;
  bit m_ovf;
  bit m_crderr;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic reqflit_t mkflit(input logic [47:0] addr, input logic [11:0] txn);
    reqflit_t f;
    f.addr          = addr;
    f.size          = 3'($urandom);
    f.txn_id        = txn;
    f.src_id        = 11'($urandom);
    f.return_nid    = 11'($urandom);
    f.return_txn_id = 12'($urandom);
    return f;
  endfunction

  function automatic reqflit_t rndflit();
    return mkflit({16'($urandom), 32'($urandom)}, 12'($urandom));
  endfunction

  // Monitor: every flit the DUT presents must be the oldest accepted one
  always @(negedge clock) begin
    if (reset && txreq_flitv) begin
      sent_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL flit_order: got txn=%03h addr=%012h want no flit", txreq_flit.txn_id, txreq_flit.addr);
      end else begin
        mon_exp = exp_q.pop_front();
        if (txreq_flit !== mon_exp) begin
          fails++;
          $display("FAIL flit_data: got txn=%03h addr=%012h want txn=%03h addr=%012h",
                   txreq_flit.txn_id, txreq_flit.addr, mon_exp.txn_id, mon_exp.addr);
        end else begin
          $display("[TB] flit out txn=%03h addr=%012h", txreq_flit.txn_id, txreq_flit.addr);
        end
      end
    end
  end

  // Model update for one clock edge with the given inputs
  task automatic model_edge(input bit v, input reqflit_t f, input bit c);
    bit snd;
    bit psh;
    snd = (m_cnt != 0) && (m_crd != 0) && m_pend;
    psh = v && (m_cnt < DEPTH);
    if (v && !psh) m_ovf = 1'b1;
    if (psh) exp_q.push_back(f);
    if (c && !snd && m_crd == MAX_CRD) m_crderr = 1'b1;
    else m_crd = m_crd + int'(c) - int'(snd);
    m_cnt   = m_cnt + int'(psh) - int'(snd);
    m_pend  = (m_cnt != 0);
    m_flitv = snd;
  endtask

  task automatic check_all();
    chk("flitv", txreq_flitv, m_flitv);
    chk("flitpend", txreq_flitpend, m_pend);
    chk("occupancy", occupancy, m_cnt);
    chk("full", full, m_cnt == DEPTH);
    chk("overflow", overflow, m_ovf);
    chk("crd_err", crd_err, m_crderr);
  endtask

  // One clock cycle: drive at negedge, model at posedge, check at negedge
  task automatic cycle(input bit v, input reqflit_t f, input bit c);
    read_no_snp   = f;
    read_no_snp_v = v;
    txreq_lcrdv   = c;
    @(posedge clock);
    model_edge(v, f, c);
    @(negedge clock);
    check_all();
  endtask

  task automatic idle(input int n, input bit c);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, c);
  endtask

  // Asynchronous reset between edges; outputs must clear at once
  task automatic do_reset();
    #2;
    reset = 1'b0;
    read_no_snp_v = 1'b0;
    txreq_lcrdv   = 1'b0;
    #1;
    chk("rst_flitv", txreq_flitv, 0);
    chk("rst_flitpend", txreq_flitpend, 0);
    chk("rst_flit_nonzero", longint'(txreq_flit != '0), 0);
    chk("rst_full", full, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_crd_err", crd_err, 0);
    m_cnt = 0; m_crd = 0; m_pend = 0; m_flitv = 0; m_ovf = 0; m_crderr = 0;
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  int s0;

  initial begin
    // 1: one flit with no credit, then a single credit
    do_reset();
    cycle(1'b1, mkflit(48'h1000, 12'd5), 1'b0);
    chk("t1_pend_next", txreq_flitpend, 1);
    s0 = sent_cnt;
    idle(10, 1'b0);
    chk("t1_stall", sent_cnt - s0, 0);
    cycle(1'b0, '0, 1'b1);
    idle(1, 1'b0);
    chk("t1_flitv_2cyc", txreq_flitv, 1);
    idle(2, 1'b0);
    chk("t1_one_flit", sent_cnt - s0, 1);
    cycle(1'b1, mkflit(48'h2000, 12'd6), 1'b0);
    idle(5, 1'b0);
    chk("t1_crd_zero", sent_cnt - s0, 1);

    // 2: latency and streaming with 3 preloaded credits
    do_reset();
    idle(3, 1'b1);
    s0 = sent_cnt;
    for (int i = 1; i <= 3; i++) cycle(1'b1, mkflit(48'h3000 + 48'(i), 12'(i)), 1'b0);
    idle(3, 1'b0);
    chk("t2_three_sent", sent_cnt - s0, 3);
    cycle(1'b1, mkflit(48'h3100, 12'd9), 1'b0);
    idle(4, 1'b0);
    chk("t2_crd_zero", sent_cnt - s0, 3);

    // 3: partial credit
    do_reset();
    idle(2, 1'b1);
    s0 = sent_cnt;
    for (int i = 0; i < 4; i++) cycle(1'b1, rndflit(), 1'b0);
    idle(4, 1'b0);
    chk("t3_sent2", sent_cnt - s0, 2);
    chk("t3_occ2", occupancy, 2);
    chk("t3_notfull", full, 0);
    idle(2, 1'b1);
    idle(4, 1'b0);
    chk("t3_sent4", sent_cnt - s0, 4);
    chk("t3_occ0", occupancy, 0);

    // 4: overflow with no credit
    do_reset();
    s0 = sent_cnt;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, rndflit(), 1'b0);
      if (i == 3) chk("t4_full_after4", full, 1);
    end
    chk("t4_overflow", overflow, 1);
    idle(4, 1'b1);
    idle(6, 1'b0);
    chk("t4_four_out", sent_cnt - s0, 4);
    chk("t4_ovf_sticky", overflow, 1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 99) < 60, rndflit(), $urandom_range(0, 99) < 45);
    end
    for (int i = 0; i < 50 && m_cnt != 0; i++) idle(1, 1'b1);
    idle(3, 1'b0);
    chk("rand_drained", exp_q.size(), 0);

    // 5a: credit saturation
    do_reset();
    idle(16, 1'b1);
    chk("t5_crd_err", crd_err, 1);
    s0 = sent_cnt;
    for (int i = 0; i < 22; i++) cycle(1'b1, rndflit(), 1'b0);
    idle(6, 1'b0);
    chk("t5_crd15", sent_cnt - s0, 15);

    // 5b: concurrent credit return and send keeps one credit
    do_reset();
    idle(1, 1'b1);
    s0 = sent_cnt;
    cycle(1'b1, rndflit(), 1'b0);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, rndflit(), 1'b1);
      chk("t5_stream_flitv", txreq_flitv, 1);
    end
    idle(3, 1'b0);
    chk("t5_stream_cnt", sent_cnt - s0, 13);
    cycle(1'b1, rndflit(), 1'b0);
    idle(4, 1'b0);
    chk("t5_crd_after", sent_cnt - s0, 13);

    // 6: reset while a flit is on the link
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, rndflit(), 1'b0);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    chk("t6_flitv_before", txreq_flitv, 1);
    do_reset();
    s0 = sent_cnt;
    idle(5, 1'b0);
    chk("t6_nothing", sent_cnt - s0, 0);
    cycle(1'b0, '0, 1'b1);
    idle(3, 1'b0);
    chk("t6_credit_only", sent_cnt - s0, 0);
    cycle(1'b1, mkflit(48'h6000, 12'h66), 1'b0);
    idle(4, 1'b0);
    chk("t6_new_flit", sent_cnt - s0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
